// File: rtl/alarm_unit.sv
// alarm_unit: user-editable alarm time compared against the live wall clock,
// with a ringing/snooze state machine and a 1 Hz buzzer output.
// Optional feature macro: ALARM_SNOOZE_EN (SNOOZE state and snooze counter).
// Without it, snooze_pulse silences the alarm exactly like stop_pulse.
module alarm_unit #(
    parameter int RESET_HOUR     = 7,
    parameter int RESET_MIN      = 0,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       set_mode,
    input  logic       sel_pulse,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    input  logic       arm_toggle,
    input  logic       stop_pulse,
    input  logic       snooze_pulse,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       field_sel,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    localparam logic [4:0] RST_HOUR  = 5'(RESET_HOUR);
    localparam logic [5:0] RST_MIN   = 6'(RESET_MIN);
    localparam logic [7:0] RING_LOAD = 8'(RING_SECONDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [4:0] hour_reg, hour_next;
    logic [5:0] min_reg, min_next;
    logic       field_reg, field_next;
    logic       armed_reg, armed_next;
    logic       match_d_reg;
    logic [7:0] ring_reg, ring_next;
    logic       buzz_reg, buzz_next;
    logic       ringing_reg, snoozing_reg;
    logic       match, trigger, silence;

`ifdef ALARM_SNOOZE_EN
    localparam logic [9:0] SNZ_LOAD = 10'(SNOOZE_MINUTES * 60);
    logic [9:0] snz_reg, snz_next;
`endif

    // Alarm-time editing: field select and wrapped increment/decrement, set mode only
    always_comb begin
        hour_next  = hour_reg;
        min_next   = min_reg;
        field_next = field_reg;
        if (set_mode) begin
            if (sel_pulse)
                field_next = ~field_reg;
            // inc/dec act on the field selected before any simultaneous sel_pulse
            if (inc_pulse && !dec_pulse) begin
                if (!field_reg)
                    hour_next = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
                else
                    min_next = (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
            end else if (dec_pulse && !inc_pulse) begin
                if (!field_reg)
                    hour_next = (hour_reg == 5'd0) ? 5'd23 : hour_reg - 5'd1;
                else
                    min_next = (min_reg == 6'd0) ? 6'd59 : min_reg - 6'd1;
            end
        end
        armed_next = armed_reg ^ arm_toggle;
    end

    // Rising edge of the time match so a held second-zero only triggers once
    assign match   = armed_reg && (cur_hour == hour_reg) && (cur_min == min_reg)
                     && (cur_sec == 6'd0);
    assign trigger = match && !match_d_reg;

`ifdef ALARM_SNOOZE_EN
    assign silence = stop_pulse;
`else
    assign silence = stop_pulse || snooze_pulse;
`endif

    // Next-state and counter logic; pulses take priority over the tick
    always_comb begin
        state_next = state_reg;
        ring_next  = ring_reg;
        buzz_next  = buzz_reg;
`ifdef ALARM_SNOOZE_EN
        snz_next   = snz_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                buzz_next = 1'b0;
                if (trigger) begin
                    state_next = ST_RINGING;
                    ring_next  = RING_LOAD;
                    buzz_next  = 1'b1;
                end
            end
            ST_RINGING: begin
                if (silence) begin
                    state_next = ST_IDLE;
                    buzz_next  = 1'b0;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze_pulse) begin
                    state_next = ST_SNOOZE;
                    snz_next   = SNZ_LOAD;
                    buzz_next  = 1'b0;
`endif
                end else if (tick_1hz) begin
                    ring_next = ring_reg - 8'd1;
                    buzz_next = ~buzz_reg;
                    if (ring_reg <= 8'd1) begin
                        state_next = ST_IDLE;
                        buzz_next  = 1'b0;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                buzz_next = 1'b0;
                if (stop_pulse) begin
                    state_next = ST_IDLE;
                end else if (tick_1hz) begin
                    snz_next = snz_reg - 10'd1;
                    if (snz_reg <= 10'd1) begin
                        state_next = ST_RINGING;
                        ring_next  = RING_LOAD;
                        buzz_next  = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
                buzz_next  = 1'b0;
            end
        endcase
        // Disarming always silences, whatever the state
        if (!armed_next) begin
            state_next = ST_IDLE;
            buzz_next  = 1'b0;
        end
    end

    // Alarm time, field select, arm flag and match history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_reg    <= RST_HOUR;
            min_reg     <= RST_MIN;
            field_reg   <= 1'b0;
            armed_reg   <= 1'b0;
            match_d_reg <= 1'b0;
        end else begin
            hour_reg    <= hour_next;
            min_reg     <= min_next;
            field_reg   <= field_next;
            armed_reg   <= armed_next;
            match_d_reg <= match;
        end
    end

    // FSM state, counters and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ring_reg     <= 8'd0;
            buzz_reg     <= 1'b0;
            ringing_reg  <= 1'b0;
            snoozing_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ring_reg     <= ring_next;
            buzz_reg     <= buzz_next;
            ringing_reg  <= (state_next == ST_RINGING);
            snoozing_reg <= (state_next == ST_SNOOZE);
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze countdown, seconds remaining before ringing resumes
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            snz_reg <= 10'd0;
        else
            snz_reg <= snz_next;
    end
`endif

    assign alarm_hour = hour_reg;
    assign alarm_min  = min_reg;
    assign field_sel  = field_reg;
    assign armed      = armed_reg;
    assign ringing    = ringing_reg;
    assign snoozing   = snoozing_reg;
    assign buzzer     = buzz_reg;

endmodule
